// File: rtl/comparator_pkg.sv
// Shared types and sizing helpers for the bit-serial magnitude comparator.
package comparator_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Width of a counter that must represent 0..n inclusive.
  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  localparam int unsigned DEFAULT_N = 4;

endpackage

// File: rtl/bit_counter.sv
// Consumed-bit counter for the serial comparator.
// Ports: clock/reset (async, active-high), clear (sync zero), inc (+1),
//        count (current value), last (count == N-1, i.e. next bit is the final one).
module bit_counter
  import comparator_pkg::*;
#(
  parameter int unsigned N = DEFAULT_N
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   inc,
  output logic [cnt_w(N)-1:0]    count,
  output logic                   last
);

  localparam int unsigned CW = cnt_w(N);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // clear wins over inc so a restart never carries a stale increment
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign last  = (count_q == CW'(N - 1));

endmodule

// File: rtl/serial_comparator.sv
// Bit-serial unsigned comparator: consumes N bit pairs LSB first and reports
// x==y / x>y / x<y. The most significant differing pair seen so far decides.
// Ports: clock, reset (async, active-high), start, abort, bit_valid, xb, yb in;
//        busy (in SHIFT), done (1-cycle pulse), eq/gt/lt flags, bit_count out.
// All outputs are registered.
module serial_comparator
  import comparator_pkg::*;
#(
  parameter int unsigned N = DEFAULT_N
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   bit_valid,
  input  logic                   xb,
  input  logic                   yb,
  output logic                   busy,
  output logic                   done,
  output logic                   eq,
  output logic                   gt,
  output logic                   lt,
  output logic [cnt_w(N)-1:0]    bit_count
);

  localparam int unsigned CW = cnt_w(N);

  state_e state_q, state_d;
  logic   eq_q, eq_d;
  logic   gt_q, gt_d;
  logic   lt_q, lt_d;
  logic   busy_q, done_q;
  logic   cnt_clear, cnt_inc, cnt_last;
  logic [CW-1:0] cnt;

  bit_counter #(.N(N)) u_bit_counter (
    .clock (clock),
    .reset (reset),
    .clear (cnt_clear),
    .inc   (cnt_inc),
    .count (cnt),
    .last  (cnt_last)
  );

  // Next-state, flag update and counter control
  always_comb begin
    state_d   = state_q;
    eq_d      = eq_q;
    gt_d      = gt_q;
    lt_d      = lt_q;
    cnt_clear = 1'b0;
    cnt_inc   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = SHIFT;
          eq_d      = 1'b1;
          gt_d      = 1'b0;
          lt_d      = 1'b0;
          cnt_clear = 1'b1;
        end
      end
      SHIFT: begin
        // abort outranks both a valid bit and completion on the final bit
        if (abort) begin
          state_d   = IDLE;
          eq_d      = 1'b1;
          gt_d      = 1'b0;
          lt_d      = 1'b0;
          cnt_clear = 1'b1;
        end else if (bit_valid) begin
          cnt_inc = 1'b1;
          // later pairs are more significant, so a new difference overrides
          if (xb != yb) begin
            eq_d = 1'b0;
            gt_d = xb;
            lt_d = yb;
          end
          if (cnt_last) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Registered outputs; busy/done track the state being entered so they align with it
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      eq_q   <= 1'b1;
      gt_q   <= 1'b0;
      lt_q   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      eq_q   <= eq_d;
      gt_q   <= gt_d;
      lt_q   <= lt_d;
      busy_q <= (state_d == SHIFT);
      done_q <= (state_d == DONE);
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign eq        = eq_q;
  assign gt        = gt_q;
  assign lt        = lt_q;
  assign bit_count = cnt;

endmodule

// File: tb/tb_serial_comparator.sv
// Self-checking bench for serial_comparator (N=4): directed scenarios plus
// randomized operands, checked against an integer-comparison reference model.
module tb_serial_comparator;
  import comparator_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned CW = cnt_w(N);

  logic clock = 1'b0;
  logic reset, start, abort, bit_valid, xb, yb;
  logic busy, done, eq, gt, lt;
  logic [CW-1:0] bit_count;

  int total = 0;
  int bad = 0;
  int seen_done = 0;
  int p0;

  serial_comparator #(.N(N)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .bit_valid (bit_valid),
    .xb        (xb),
    .yb        (yb),
    .busy      (busy),
    .done      (done),
    .eq        (eq),
    .gt        (gt),
    .lt        (lt),
    .bit_count (bit_count)
  );

  always #5 clock = ~clock;

  // Reference: compare the low k bits of x and y as plain integers -> {eq,gt,lt}
  function automatic logic [2:0] ref_flags(input int unsigned x, input int unsigned y,
                                           input int k);
    int unsigned m, xa, ya;
    m  = (32'd1 << k) - 32'd1;
    xa = x & m;
    ya = y & m;
    return {xa == ya, xa > ya, xa < ya};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [2:0] f, input int cnt,
                         input logic bz, input logic dn);
    chk({tag, ".eq"},   32'(eq),        32'(f[2]));
    chk({tag, ".gt"},   32'(gt),        32'(f[1]));
    chk({tag, ".lt"},   32'(lt),        32'(f[0]));
    chk({tag, ".cnt"},  32'(bit_count), 32'(cnt));
    chk({tag, ".busy"}, 32'(busy),      32'(bz));
    chk({tag, ".done"}, 32'(done),      32'(dn));
  endtask

  // Advance to the next falling edge and tally done pulses
  task automatic step();
    @(negedge clock);
    if (done === 1'b1) seen_done++;
  endtask

  // One operation: start, N valid pairs with random idle gaps, optional abort
  // on pair index abort_at, optional ignored start/abort noise.
  task automatic run_op(input int unsigned x, input int unsigned y, input int gap_lo,
                        input int gap_hi, input int abort_at, input bit noise,
                        input bit vld_with_start);
    int pulses0, nsteps, gaps, g;
    pulses0 = seen_done;
    nsteps  = 0;
    gaps    = 0;
    start     = 1'b1;
    bit_valid = vld_with_start;
    xb        = x[0];
    yb        = ~x[0];
    step();
    nsteps++;
    start     = 1'b0;
    bit_valid = 1'b0;
    chk_out("accept", 3'b100, 0, 1'b1, 1'b0);
    for (int i = 0; i < int'(N); i++) begin
      g = int'($urandom_range(gap_hi, gap_lo));
      gaps += g;
      repeat (g) begin
        bit_valid = 1'b0;
        start     = noise && ($urandom_range(1, 0) != 0);
        step();
        nsteps++;
        chk_out("gap", ref_flags(x, y, i), i, 1'b1, 1'b0);
      end
      bit_valid = 1'b1;
      xb        = x[i];
      yb        = y[i];
      abort     = (i == abort_at);
      start     = noise && ($urandom_range(1, 0) != 0);
      step();
      nsteps++;
      bit_valid = 1'b0;
      start     = 1'b0;
      if (i == abort_at) begin
        abort = 1'b0;
        chk_out("abort", 3'b100, 0, 1'b0, 1'b0);
        step();
        step();
        chk("abort_no_done", 32'(seen_done - pulses0), 32'd0);
        return;
      end
      if (i < int'(N) - 1) chk_out("shift", ref_flags(x, y, i + 1), i + 1, 1'b1, 1'b0);
    end
    chk_out("done", ref_flags(x, y, N), N, 1'b0, 1'b1);
    chk("latency", 32'(nsteps), 32'(1 + gaps + int'(N)));
    start = noise;
    abort = noise;
    step();
    start = 1'b0;
    abort = 1'b0;
    chk_out("hold", ref_flags(x, y, N), N, 1'b0, 1'b0);
    step();
    chk_out("idle", ref_flags(x, y, N), N, 1'b0, 1'b0);
    chk("one_pulse", 32'(seen_done - pulses0), 32'd1);
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    bit_valid = 1'b0;
    xb        = 1'b0;
    yb        = 1'b0;
    #1;
    chk_out("reset", 3'b100, 0, 1'b0, 1'b0);
    step();
    reset = 1'b0;

    // Equal operands, no gaps: start accepted on first edge after reset
    run_op(32'b1010, 32'b1010, 0, 0, -1, 1'b0, 1'b0);
    // MSB difference overrides lower differing bits
    run_op(32'b1000, 32'b0111, 0, 0, -1, 1'b0, 1'b0);
    // Three idle cycles before every bit
    run_op(32'b0001, 32'b0010, 3, 3, -1, 1'b0, 1'b0);
    // Abort with the 3rd valid bit, then a fresh comparison
    run_op(32'b0111, 32'b0100, 0, 0, 2, 1'b0, 1'b0);
    run_op(32'b0110, 32'b1001, 0, 1, -1, 1'b0, 1'b0);
    // Abort on the final bit beats completion
    run_op(32'b1111, 32'b0000, 0, 0, int'(N) - 1, 1'b0, 1'b0);

    // Abort in IDLE leaves the previous result untouched
    run_op(32'b1100, 32'b0011, 0, 0, -1, 1'b0, 1'b0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk_out("idle_abort", 3'b010, N, 1'b0, 1'b0);

    // Reset after two consumed bits
    p0 = seen_done;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (2) begin
      bit_valid = 1'b1;
      xb        = 1'b1;
      yb        = 1'b0;
      step();
    end
    bit_valid = 1'b0;
    chk_out("pre_reset", 3'b010, 2, 1'b1, 1'b0);
    #1 reset = 1'b1;
    #1;
    chk_out("reset_async", 3'b100, 0, 1'b0, 1'b0);
    step();
    reset = 1'b0;
    chk("reset_no_done", 32'(seen_done - p0), 32'd0);
    // Start with a differing valid pair in the same cycle: pair must be ignored
    run_op(32'b0101, 32'b0101, 0, 0, -1, 1'b0, 1'b1);

    // Start/abort noise during SHIFT and DONE is ignored
    run_op(32'b1001, 32'b1011, 0, 2, -1, 1'b1, 1'b0);

    // Randomized operands, gaps and noise
    for (int r = 0; r < 24; r++) begin
      run_op($urandom_range(15, 0), $urandom_range(15, 0), 0, 2,
             (r % 6 == 5) ? int'($urandom_range(N - 1, 0)) : -1,
             r[0], r[1]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
